// File: rtl/mul_job_pkg.sv
// Shared definitions for the multiply job scheduler: register map,
// status bit positions, default queue depths, engine states and a
// popcount helper.
package mul_job_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_JOB  = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam int ST_HEAD_VALID = 0;
    localparam int ST_READY      = 1;
    localparam int ST_JCNT_LSB   = 2;
    localparam int ST_RCNT_LSB   = 5;
    localparam int ST_DROP       = 8;
    localparam int ST_UFLOW      = 9;
    localparam int ST_CNT_LSB    = 16;

    localparam int JQ_DEPTH_DEF = 4;
    localparam int RQ_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_COUNT = 2'd2,
        ST_WRITE = 2'd3
    } eng_state_e;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mul24_seq.sv
// 24x24 unsigned shift-add multiplier, one multiplier bit per clock.
// done is high during the clock that consumes the last (24th) bit, so the
// product register holds the final value from the following clock onward.
// popcount reflects the low 32 bits of the current product register.
module mul24_seq
    import mul_job_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] a_in,
    input  logic [23:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [47:0] product,
    output logic [5:0]  popcount
);

    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] prod_q, prod_d;
    logic [4:0]  idx_q, idx_d;
    logic        busy_q, busy_d;

    // Next-state: load on start, then one conditional add and shift per clock.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        if (abort) begin
            busy_d = 1'b0;
            idx_d  = 5'd0;
        end else if (start) begin
            mcand_d  = {24'h0, a_in};
            mplier_d = b_in;
            prod_d   = 48'h0;
            idx_d    = 5'd0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end else begin
                prod_d = prod_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (idx_q == 5'd23) begin
                busy_d = 1'b0;
                idx_d  = 5'd0;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mcand_q  <= 48'h0;
            mplier_q <= 24'h0;
            prod_q   <= 48'h0;
            idx_q    <= 5'd0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (idx_q == 5'd23);
    assign product  = prod_q;
    assign popcount = popcount32(prod_q[31:0]);

endmodule

// File: rtl/mul_job_sched.sv
// Multiply job scheduler: bus register decode, job and result queues and
// the IDLE/MULT/COUNT/WRITE engine around the mul24_seq datapath.
module mul_job_sched
    import mul_job_pkg::*;
#(
    parameter int JQ_DEPTH = JQ_DEPTH_DEF,
    parameter int RQ_DEPTH = RQ_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        swr,
    input  logic        srd,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic [31:0] gpio_out,
    output logic        irq
);

    localparam int JP_W = (JQ_DEPTH > 1) ? $clog2(JQ_DEPTH) : 1;
    localparam int JC_W = $clog2(JQ_DEPTH + 1);
    localparam int RP_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int RC_W = $clog2(RQ_DEPTH + 1);

    // Job entry {A1, A2}; result entry {W[31:0], L[5:0], valid}.
    logic [47:0] jq_mem_q [JQ_DEPTH];
    logic [47:0] jq_mem_d [JQ_DEPTH];
    logic [JP_W-1:0] jq_head_q, jq_head_d, jq_tail_q, jq_tail_d;
    logic [JC_W-1:0] jq_cnt_q, jq_cnt_d;
    logic [38:0] rq_mem_q [RQ_DEPTH];
    logic [38:0] rq_mem_d [RQ_DEPTH];
    logic [RP_W-1:0] rq_head_q, rq_head_d, rq_tail_q, rq_tail_d;
    logic [RC_W-1:0] rq_cnt_q, rq_cnt_d;

    eng_state_e  state_q, state_d;
    logic [38:0] res_q, res_d;
    logic [23:0] a1_q, a1_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic        drop_q, drop_d, uflow_q, uflow_d;
    logic [31:0] sdata_q, sdata_d, gpio_q, gpio_d;
    logic        irq_q, irq_d;

    logic        wr_job_s, wr_ctrl_s, flush_s, clr_s, rd_w_s;
    logic        jq_push_s, jq_pop_s, jq_full_s, jq_empty_s, drop_set_s;
    logic        rq_push_s, rq_pop_s, rq_full_s, rq_empty_s, uflow_set_s;
    logic        mul_start_s, mul_busy_s, mul_done_s;
    logic [47:0] mul_product_s;
    logic [5:0]  mul_popcnt_s;
    logic [47:0] jq_head_ent_s;
    logic [38:0] rq_head_ent_s;
    logic [31:0] status_s;
    logic        unused_ok_s;

    assign wr_job_s    = swr && (saddress == ADDR_JOB);
    assign wr_ctrl_s   = swr && (saddress == ADDR_CTRL);
    assign flush_s     = wr_ctrl_s && sdata_in[1];
    assign clr_s       = wr_ctrl_s && sdata_in[0];
    assign rd_w_s      = srd && (saddress == ADDR_W);
    assign jq_empty_s  = (jq_cnt_q == JC_W'(0));
    assign jq_full_s   = (jq_cnt_q == JC_W'(JQ_DEPTH));
    assign rq_empty_s  = (rq_cnt_q == RC_W'(0));
    assign rq_full_s   = (rq_cnt_q == RC_W'(RQ_DEPTH));
    assign jq_head_ent_s = jq_mem_q[jq_head_q];
    assign rq_head_ent_s = rq_mem_q[rq_head_q];
    // A full queue still accepts a push when it is popped in the same clock.
    assign jq_push_s   = wr_job_s && (!jq_full_s || jq_pop_s);
    assign drop_set_s  = wr_job_s && !jq_push_s;
    assign rq_pop_s    = rd_w_s && !rq_empty_s;
    assign uflow_set_s = rd_w_s && rq_empty_s;
    assign unused_ok_s = &{1'b0, sdata_in[31:24]};

    mul24_seq u_mul (
        .clk      (clk),
        .n_reset  (n_reset),
        .start    (mul_start_s),
        .abort    (flush_s),
        .a_in     (jq_head_ent_s[47:24]),
        .b_in     (jq_head_ent_s[23:0]),
        .busy     (mul_busy_s),
        .done     (mul_done_s),
        .product  (mul_product_s),
        .popcount (mul_popcnt_s)
    );

    // Engine sequencing; a flush abandons whatever job is in flight.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        jq_pop_s    = 1'b0;
        mul_start_s = 1'b0;
        rq_push_s   = 1'b0;
        if (flush_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!jq_empty_s) begin
                        jq_pop_s    = 1'b1;
                        mul_start_s = 1'b1;
                        state_d     = ST_MULT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MULT: begin
                    if (mul_done_s) begin
                        state_d = ST_COUNT;
                    end else begin
                        state_d = ST_MULT;
                    end
                end
                ST_COUNT: begin
                    res_d   = {mul_product_s[31:0], mul_popcnt_s,
                               (mul_product_s[47:32] == 16'h0)};
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (!rq_full_s || rq_pop_s) begin
                        rq_push_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Job queue pointers, count and storage.
    always_comb begin
        jq_mem_d  = jq_mem_q;
        jq_head_d = jq_head_q;
        jq_tail_d = jq_tail_q;
        jq_cnt_d  = jq_cnt_q;
        if (flush_s) begin
            jq_head_d = JP_W'(0);
            jq_tail_d = JP_W'(0);
            jq_cnt_d  = JC_W'(0);
        end else begin
            if (jq_push_s) begin
                jq_mem_d[jq_tail_q] = {a1_q, sdata_in[23:0]};
                jq_tail_d = (jq_tail_q == JP_W'(JQ_DEPTH - 1)) ? JP_W'(0) : jq_tail_q + JP_W'(1);
            end else begin
                jq_tail_d = jq_tail_q;
            end
            if (jq_pop_s) begin
                jq_head_d = (jq_head_q == JP_W'(JQ_DEPTH - 1)) ? JP_W'(0) : jq_head_q + JP_W'(1);
            end else begin
                jq_head_d = jq_head_q;
            end
            case ({jq_push_s, jq_pop_s})
                2'b10:   jq_cnt_d = jq_cnt_q + JC_W'(1);
                2'b01:   jq_cnt_d = jq_cnt_q - JC_W'(1);
                default: jq_cnt_d = jq_cnt_q;
            endcase
        end
    end

    // Result queue pointers, count and storage.
    always_comb begin
        rq_mem_d  = rq_mem_q;
        rq_head_d = rq_head_q;
        rq_tail_d = rq_tail_q;
        rq_cnt_d  = rq_cnt_q;
        if (flush_s) begin
            rq_head_d = RP_W'(0);
            rq_tail_d = RP_W'(0);
            rq_cnt_d  = RC_W'(0);
        end else begin
            if (rq_push_s) begin
                rq_mem_d[rq_tail_q] = res_q;
                rq_tail_d = (rq_tail_q == RP_W'(RQ_DEPTH - 1)) ? RP_W'(0) : rq_tail_q + RP_W'(1);
            end else begin
                rq_tail_d = rq_tail_q;
            end
            if (rq_pop_s) begin
                rq_head_d = (rq_head_q == RP_W'(RQ_DEPTH - 1)) ? RP_W'(0) : rq_head_q + RP_W'(1);
            end else begin
                rq_head_d = rq_head_q;
            end
            case ({rq_push_s, rq_pop_s})
                2'b10:   rq_cnt_d = rq_cnt_q + RC_W'(1);
                2'b01:   rq_cnt_d = rq_cnt_q - RC_W'(1);
                default: rq_cnt_d = rq_cnt_q;
            endcase
        end
    end

    // Status word assembled from current (pre-edge) state.
    always_comb begin
        status_s = 32'h0;
        status_s[ST_HEAD_VALID] = !rq_empty_s && rq_head_ent_s[0];
        status_s[ST_READY] = (state_q == ST_IDLE) && !mul_busy_s && jq_empty_s;
        status_s[ST_JCNT_LSB +: 3] = 3'(jq_cnt_q);
        status_s[ST_RCNT_LSB +: 3] = 3'(rq_cnt_q);
        status_s[ST_DROP]  = drop_q;
        status_s[ST_UFLOW] = uflow_q;
        status_s[ST_CNT_LSB +: 16] = done_cnt_q;
    end

    // Register-file next state; a set event wins over a same-clock clear.
    always_comb begin
        a1_d       = a1_q;
        done_cnt_d = done_cnt_q + {15'h0, rq_push_s};
        drop_d     = drop_set_s  || (drop_q  && !clr_s);
        uflow_d    = uflow_set_s || (uflow_q && !clr_s);
        sdata_d    = sdata_q;
        if (swr && (saddress == ADDR_A1)) begin
            a1_d = sdata_in[23:0];
        end else begin
            a1_d = a1_q;
        end
        if (srd) begin
            case (saddress)
                ADDR_W:    sdata_d = rq_pop_s ? rq_head_ent_s[38:7] : 32'h0;
                ADDR_L:    sdata_d = rq_empty_s ? 32'h0 : {26'h0, rq_head_ent_s[6:1]};
                ADDR_CTRL: sdata_d = status_s;
                default:   sdata_d = 32'h0;
            endcase
        end else begin
            sdata_d = sdata_q;
        end
        gpio_d = {16'h0, done_cnt_d};
        irq_d  = (rq_cnt_d != RC_W'(0));
    end

    // All scheduler state; reset empties the queues and clears the outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < JQ_DEPTH; i++) jq_mem_q[i] <= 48'h0;
            for (int i = 0; i < RQ_DEPTH; i++) rq_mem_q[i] <= 39'h0;
            jq_head_q  <= JP_W'(0);
            jq_tail_q  <= JP_W'(0);
            jq_cnt_q   <= JC_W'(0);
            rq_head_q  <= RP_W'(0);
            rq_tail_q  <= RP_W'(0);
            rq_cnt_q   <= RC_W'(0);
            state_q    <= ST_IDLE;
            res_q      <= 39'h0;
            a1_q       <= 24'h0;
            done_cnt_q <= 16'h0;
            drop_q     <= 1'b0;
            uflow_q    <= 1'b0;
            sdata_q    <= 32'h0;
            gpio_q     <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            jq_mem_q   <= jq_mem_d;
            rq_mem_q   <= rq_mem_d;
            jq_head_q  <= jq_head_d;
            jq_tail_q  <= jq_tail_d;
            jq_cnt_q   <= jq_cnt_d;
            rq_head_q  <= rq_head_d;
            rq_tail_q  <= rq_tail_d;
            rq_cnt_q   <= rq_cnt_d;
            state_q    <= state_d;
            res_q      <= res_d;
            a1_q       <= a1_d;
            done_cnt_q <= done_cnt_d;
            drop_q     <= drop_d;
            uflow_q    <= uflow_d;
            sdata_q    <= sdata_d;
            gpio_q     <= gpio_d;
            irq_q      <= irq_d;
        end
    end

    assign sdata_out = sdata_q;
    assign gpio_out  = gpio_q;
    assign irq       = irq_q;

endmodule
